// File: rtl/md5_search_ctrl.sv
// Brute-force candidate sequencer for a pipelined md5core: issues one candidate
// string per clock and watches the core output for the target digest.
module md5_search_ctrl #(
   parameter int unsigned LAT        = 65,
   parameter int unsigned MAX_CHARS  = 8,
   parameter logic [7:0]  CHAR_FIRST = 8'h61,
   parameter int unsigned CHAR_COUNT = 26
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] target_hash,
   input  logic [3:0]   start_len,
   input  logic [3:0]   max_len,
   output logic [511:0] md_message,
   output logic [63:0]  md_length,
   input  logic [127:0] md_hash,
   input  logic [511:0] md_message_out,
   output logic         busy,
   output logic         found,
   output logic         done,
   output logic [511:0] found_msg,
   output logic [47:0]  cand_count
);

   localparam int unsigned   DW          = (CHAR_COUNT > 1) ? $clog2(CHAR_COUNT) : 1;
   localparam logic [DW-1:0] DIG_LAST    = DW'(CHAR_COUNT - 1);
   localparam logic [5:0]    MAX_LEN_LIM = 6'(MAX_CHARS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   digit_q [MAX_CHARS];
   logic [DW-1:0]   digit_d [MAX_CHARS];
   logic [DW-1:0]   inc_digit_s [MAX_CHARS];
   logic [5:0]      len_q, len_d;
   logic [5:0]      max_len_q, max_len_d;
   logic [5:0]      md_len_q, md_len_d;
   logic [127:0]    target_q, target_d;
   logic [511:0]    msg_q, msg_d;
   logic [511:0]    cand_msg_s;
   logic            md_valid_q, md_valid_d;
   logic [LAT-1:0]  valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            found_q, found_d;
   logic            done_q, done_d;
   logic [511:0]    found_msg_q, found_msg_d;
   logic [47:0]     cnt_q, cnt_d;
   logic            carry_s;
   logic            start_ok_s;
   logic            hit_s;
   logic            drain_empty_s;

   // md_valid_q marks the candidate sitting on md_message; valid_q then tracks it through the core.
   assign start_ok_s    = (start_len != 4'd0) && ({2'b00, start_len} <= MAX_LEN_LIM) &&
                          ({2'b00, max_len} <= MAX_LEN_LIM) && (max_len >= start_len);
   assign hit_s         = valid_q[LAT-1] && (md_hash == target_q);
   assign drain_empty_s = !md_valid_q && (valid_q[LAT-2:0] == '0);

   // Candidate image of the current digits and its odometer increment.
   always_comb begin
      cand_msg_s  = '0;
      inc_digit_s = digit_q;
      carry_s     = 1'b1;
      for (int i = 0; i < int'(MAX_CHARS); i++) begin
         if (6'(i) < len_q) begin
            cand_msg_s[511-8*i -: 8] = CHAR_FIRST + 8'(digit_q[i]);
         end else begin
            cand_msg_s[511-8*i -: 8] = 8'h00;
         end
      end
      for (int i = int'(MAX_CHARS) - 1; i >= 0; i--) begin
         if (carry_s && (6'(i) < len_q)) begin
            if (digit_q[i] == DIG_LAST) begin
               inc_digit_s[i] = '0;
            end else begin
               inc_digit_s[i] = digit_q[i] + DW'(1);
               carry_s        = 1'b0;
            end
         end else begin
            inc_digit_s[i] = digit_q[i];
         end
      end
   end

   // Next-state and datapath update for the search FSM.
   always_comb begin
      state_d     = state_q;
      digit_d     = digit_q;
      len_d       = len_q;
      max_len_d   = max_len_q;
      target_d    = target_q;
      msg_d       = msg_q;
      md_len_d    = md_len_q;
      md_valid_d  = 1'b0;
      valid_d     = {valid_q[LAT-2:0], md_valid_q};
      found_d     = found_q;
      done_d      = done_q;
      found_msg_d = found_msg_q;
      cnt_d       = cnt_q;
      if (abort) begin
         state_d = S_IDLE;
         valid_d = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start && start_ok_s) begin
                  target_d  = target_hash;
                  len_d     = {2'b00, start_len};
                  max_len_d = {2'b00, max_len};
                  for (int i = 0; i < int'(MAX_CHARS); i++) digit_d[i] = '0;
                  found_d   = 1'b0;
                  done_d    = 1'b0;
                  cnt_d     = 48'd0;
                  valid_d   = '0;
                  state_d   = S_RUN;
               end else begin
                  state_d = state_q;
               end
            end
            S_RUN: begin
               msg_d      = cand_msg_s;
               md_len_d   = len_q;
               md_valid_d = 1'b1;
               cnt_d      = cnt_q + 48'd1;
               if (!carry_s) begin
                  digit_d = inc_digit_s;
               end else if (len_q == max_len_q) begin
                  state_d = S_DRAIN;
               end else begin
                  len_d = len_q + 6'd1;
                  for (int i = 0; i < int'(MAX_CHARS); i++) digit_d[i] = '0;
               end
            end
            S_DRAIN: begin
               if (drain_empty_s) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DRAIN;
               end
            end
            default: state_d = S_IDLE;
         endcase
         // First match wins and also covers a match on the very last drained candidate.
         if ((state_q == S_RUN || state_q == S_DRAIN) && hit_s) begin
            found_d     = 1'b1;
            done_d      = 1'b1;
            found_msg_d = md_message_out;
            state_d     = S_DONE;
         end else begin
            found_d = found_d;
         end
         if (state_d == S_DONE) begin
            valid_d    = '0;
            md_valid_d = 1'b0;
         end else begin
            md_valid_d = md_valid_d;
         end
      end
      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < int'(MAX_CHARS); i++) digit_q[i] <= '0;
         len_q       <= 6'd0;
         max_len_q   <= 6'd0;
         md_len_q    <= 6'd0;
         target_q    <= 128'd0;
         msg_q       <= 512'd0;
         md_valid_q  <= 1'b0;
         valid_q     <= '0;
         busy_q      <= 1'b0;
         found_q     <= 1'b0;
         done_q      <= 1'b0;
         found_msg_q <= 512'd0;
         cnt_q       <= 48'd0;
      end else begin
         state_q     <= state_d;
         digit_q     <= digit_d;
         len_q       <= len_d;
         max_len_q   <= max_len_d;
         md_len_q    <= md_len_d;
         target_q    <= target_d;
         msg_q       <= msg_d;
         md_valid_q  <= md_valid_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         found_q     <= found_d;
         done_q      <= done_d;
         found_msg_q <= found_msg_d;
         cnt_q       <= cnt_d;
      end
   end

   assign md_message = msg_q;
   assign md_length  = {55'd0, md_len_q, 3'b000};
   assign busy       = busy_q;
   assign found      = found_q;
   assign done       = done_q;
   assign found_msg  = found_msg_q;
   assign cand_count = cnt_q;

endmodule
